// File: rtl/core_config_pkg.sv
// core_config_pkg: CSR addresses, mstatus bit positions and misa value shared by the CSR file.
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int CSR_ADDR_W = 12;
    typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MISA      = 12'h301;
    localparam csr_addr_t CSR_MIE       = 12'h304;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MTVAL     = 12'h343;
    localparam csr_addr_t CSR_MIP       = 12'h344;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_CYCLE     = 12'hC00;
    localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
    localparam csr_addr_t CSR_INSTRET   = 12'hC02;
    localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
    localparam csr_addr_t CSR_MHARTID   = 12'hF14;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam xlen_t MISA_VAL  = 32'h4000_0100;
    localparam xlen_t MIE_MASK  = 32'h0000_0888;
    function automatic logic csr_supported(input csr_addr_t a);
        return a inside {CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                         CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
                         CSR_MINSTRETH, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_MHARTID};
    endfunction
endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR read/write port between the core (master) and the CSR file (slave).
interface csr_file_if;
    import core_config_pkg::*;
    csr_addr_t csr_ra;
    csr_addr_t csr_wa;
    xlen_t     csr_rd;
    xlen_t     csr_wd;
    logic      csr_we;
    logic      csr_err;
    modport master (output csr_ra, csr_wa, csr_wd, csr_we, input csr_rd, csr_err);
    modport slave  (input csr_ra, csr_wa, csr_wd, csr_we, output csr_rd, csr_err);
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free/conditional counter whose halves can be loaded independently.
module csr_counter64
    import core_config_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_ld_lo,
    input  logic              i_ld_hi,
    input  xlen_t             i_wd,
    output logic [2*XLEN-1:0] o_cnt
);
    logic [2*XLEN-1:0] r_cnt;
    // a load in either half replaces that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_ld_lo) r_cnt[XLEN-1:0] <= i_wd;
        else if (i_ld_hi) r_cnt[2*XLEN-1:XLEN] <= i_wd;
        else if (i_inc) r_cnt <= r_cnt + 1'b1;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry/return, interrupt pending and 64-bit counters.
module csr_file
    import core_config_pkg::*;
#(
    parameter xlen_t MHARTID   = 32'h0,
    parameter xlen_t MTVEC_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    csr_file_if.slave   bus,
    input  logic        retire,
    input  logic        irq_ext,
    input  logic        irq_tim,
    input  logic        irq_sw,
    input  logic        trap_valid,
    input  xlen_t       trap_pc,
    input  xlen_t       trap_cause,
    input  xlen_t       trap_val,
    input  logic        mret,
    output xlen_t       trap_vector,
    output xlen_t       epc,
    output logic        irq_pending
);
    logic  r_st_mie, r_st_mpie;
    xlen_t r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    xlen_t w_rd, w_mstatus, w_mip;
    logic  [2*XLEN-1:0] w_mcycle, w_minstret;
    logic  w_wr_ok;
    csr_addr_t w_wa;
    assign w_wa    = bus.csr_wa;
    // read-only space (wa[11:10]==3) and mip are rejected along with unknown addresses
    assign w_wr_ok = bus.csr_we && csr_supported(w_wa) && w_wa[11:10] != 2'b11 && w_wa != CSR_MIP;
    assign bus.csr_err = !csr_supported(bus.csr_ra) || (bus.csr_we && !w_wr_ok);
    assign w_mstatus = 32'h0000_1800 | (xlen_t'(r_st_mpie) << MSTATUS_MPIE) | (xlen_t'(r_st_mie) << MSTATUS_MIE);
    assign w_mip     = {20'b0, irq_ext, 3'b0, irq_tim, 3'b0, irq_sw, 3'b0};
    assign irq_pending = r_st_mie && |(w_mip & r_mie);
    assign trap_vector = r_mtvec;
    assign epc         = r_mepc;
    csr_counter64 u_mcycle (
        .clk(clk), .rst(rst), .i_inc(1'b1),
        .i_ld_lo(w_wr_ok && w_wa == CSR_MCYCLE), .i_ld_hi(w_wr_ok && w_wa == CSR_MCYCLEH),
        .i_wd(bus.csr_wd), .o_cnt(w_mcycle)
    );
    csr_counter64 u_minstret (
        .clk(clk), .rst(rst), .i_inc(retire),
        .i_ld_lo(w_wr_ok && w_wa == CSR_MINSTRET), .i_ld_hi(w_wr_ok && w_wa == CSR_MINSTRETH),
        .i_wd(bus.csr_wd), .o_cnt(w_minstret)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            if (w_wr_ok && w_wa == CSR_MIE) r_mie <= bus.csr_wd & MIE_MASK;
            if (w_wr_ok && w_wa == CSR_MTVEC) r_mtvec <= bus.csr_wd & ~32'h3;
            if (w_wr_ok && w_wa == CSR_MSCRATCH) r_mscratch <= bus.csr_wd;
            // trap entry owns mstatus/mepc/mcause/mtval for the cycle, then mret, then CSR writes
            if (trap_valid) begin
                r_mepc    <= trap_pc & ~32'h3;
                r_mcause  <= trap_cause;
                r_mtval   <= trap_val;
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else begin
                if (mret) begin
                    r_st_mie  <= r_st_mpie;
                    r_st_mpie <= 1'b1;
                end else if (w_wr_ok && w_wa == CSR_MSTATUS) begin
                    r_st_mie  <= bus.csr_wd[MSTATUS_MIE];
                    r_st_mpie <= bus.csr_wd[MSTATUS_MPIE];
                end
                if (w_wr_ok && w_wa == CSR_MEPC) r_mepc <= bus.csr_wd & ~32'h3;
                if (w_wr_ok && w_wa == CSR_MCAUSE) r_mcause <= bus.csr_wd;
                if (w_wr_ok && w_wa == CSR_MTVAL) r_mtval <= bus.csr_wd;
            end
        end
    end
    always_comb begin
        w_rd = '0;
        case (bus.csr_ra)
            CSR_MSTATUS:                w_rd = w_mstatus;
            CSR_MISA:                   w_rd = MISA_VAL;
            CSR_MIE:                    w_rd = r_mie;
            CSR_MTVEC:                  w_rd = r_mtvec;
            CSR_MSCRATCH:               w_rd = r_mscratch;
            CSR_MEPC:                   w_rd = r_mepc;
            CSR_MCAUSE:                 w_rd = r_mcause;
            CSR_MTVAL:                  w_rd = r_mtval;
            CSR_MIP:                    w_rd = w_mip;
            CSR_MCYCLE, CSR_CYCLE:      w_rd = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:    w_rd = w_mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET, CSR_INSTRET:  w_rd = w_minstret[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_rd = w_minstret[2*XLEN-1:XLEN];
            CSR_MHARTID:                w_rd = MHARTID;
            default:                    w_rd = '0;
        endcase
    end
    assign bus.csr_rd = w_rd;
endmodule
